// File: rtl/fpsr_pkg.sv
// ---------------------------------------------------------------------------
// fpsr_pkg
// Shared definitions for the frame-paced prompt sprite blocks:
//   - state encoding of the prompt sequencer (plain localparams plus an enum)
//   - screen constants and the default overlay colour
// ---------------------------------------------------------------------------
package fpsr_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SLIDE_IN  = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] SLIDE_OUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = IDLE,
    S_SLIDE_IN  = SLIDE_IN,
    S_HOLD      = HOLD,
    S_SLIDE_OUT = SLIDE_OUT
  } fpsr_state_e;

  localparam logic [11:0] WHITE     = 12'hFFF;
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

endpackage

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Produces one registered single-cycle pulse per frame, in the cycle after
// the VGA counters sit at pixel 0 of FRAME_LINE (first blanked line).
// Ports:
//   clk     pixel clock
//   rst     asynchronous reset, active-low
//   hCount  horizontal pixel counter
//   vCount  vertical line counter
//   tick    one-cycle frame pulse
// ---------------------------------------------------------------------------
module frame_tick_gen
  import fpsr_pkg::*;
#(
  parameter int unsigned FRAME_LINE = V_VISIBLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       tick
);

  localparam logic [9:0] FRAME_LINE_V = 10'(FRAME_LINE);

  // hCount==0 lasts a single pixel clock, so this fires once per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= 1'b0;
    end else begin
      tick <= (hCount == 10'd0) && (vCount == FRAME_LINE_V);
    end
  end

endmodule

// File: rtl/prompt_sequencer.sv
// ---------------------------------------------------------------------------
// prompt_sequencer
// Frame-synchronous controller for the prompt sprite overlay: slides the
// prompt in to Y_TARGET, holds it (optionally blinking, optionally timing
// out), then slides it back to Y_START.
// Ports:
//   clk       pixel clock
//   rst       asynchronous reset, active-low
//   hCount    horizontal pixel counter from VGA sync
//   vCount    vertical line counter from VGA sync
//   start     one-cycle request to show the prompt
//   dismiss   one-cycle request to remove the prompt
//   blink_en  level, blink the prompt while holding
//   en        overlay enable to the sprite controller
//   y_pos     top row of the prompt sprite
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse when the slide-out completes
// ---------------------------------------------------------------------------
module prompt_sequencer
  import fpsr_pkg::*;
#(
  parameter int unsigned FRAME_LINE     = 480,
  parameter int unsigned Y_START        = 490,
  parameter int unsigned Y_TARGET       = 250,
  parameter int unsigned SLIDE_STEP     = 8,
  parameter int unsigned BLINK_FRAMES   = 30,
  parameter int unsigned TIMEOUT_FRAMES = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       start,
  input  logic       dismiss,
  input  logic       blink_en,
  output logic       en,
  output logic [9:0] y_pos,
  output logic       busy,
  output logic       done
);

  localparam int HOLD_W  = $clog2(TIMEOUT_FRAMES) + 1;
  localparam int BLINK_W = $clog2(BLINK_FRAMES) + 1;

  localparam logic [9:0]         Y_START_V  = 10'(Y_START);
  localparam logic [9:0]         Y_TARGET_V = 10'(Y_TARGET);
  localparam logic [9:0]         STEP_V     = 10'(SLIDE_STEP);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(TIMEOUT_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  fpsr_state_e        state;
  logic               tick;
  logic               start_pend;
  logic               dismiss_pend;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic [9:0]         y_in_next;
  logic [9:0]         y_out_next;
  logic               timeout_hit;
  logic               blink_wrap;

  frame_tick_gen #(
    .FRAME_LINE(FRAME_LINE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .hCount (hCount),
    .vCount (vCount),
    .tick   (tick)
  );

  // Distances are checked before stepping so the position saturates at the
  // endpoint instead of overshooting or wrapping.
  assign y_in_next   = ((y_pos - Y_TARGET_V) <= STEP_V) ? Y_TARGET_V : (y_pos - STEP_V);
  assign y_out_next  = ((Y_START_V - y_pos) <= STEP_V) ? Y_START_V : (y_pos + STEP_V);
  assign timeout_hit = (TIMEOUT_FRAMES != 0) && (hold_cnt == HOLD_LAST);
  assign blink_wrap  = (blink_cnt == BLINK_LAST);

  // Requests arrive on any cycle but are only acted on at the frame tick.
  // A dismiss is meaningless outside SLIDE_IN/HOLD, so the flag is held
  // clear there; that also drops one that lands on the tick leaving HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_pend   <= 1'b0;
      dismiss_pend <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (tick && start_pend) begin
          start_pend <= 1'b0;
        end else if (start) begin
          start_pend <= 1'b1;
        end
      end

      if ((state == S_SLIDE_IN) || (state == S_HOLD)) begin
        if (tick && dismiss_pend) begin
          dismiss_pend <= 1'b0;
        end else if (dismiss) begin
          dismiss_pend <= 1'b1;
        end
      end else begin
        dismiss_pend <= 1'b0;
      end
    end
  end

  // Sequencer. Everything visible moves only on the frame tick; done is the
  // one output that is cleared every cycle so it stays a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      en        <= 1'b0;
      y_pos     <= Y_START_V;
      busy      <= 1'b0;
      done      <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else begin
      done <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            en    <= 1'b0;
            y_pos <= Y_START_V;
            if (start_pend) begin
              state <= S_SLIDE_IN;
              busy  <= 1'b1;
              en    <= 1'b1;
            end
          end

          S_SLIDE_IN: begin
            if (dismiss_pend) begin
              state <= S_SLIDE_OUT;
            end else begin
              y_pos <= y_in_next;
              if (y_in_next == Y_TARGET_V) begin
                state     <= S_HOLD;
                hold_cnt  <= '0;
                blink_cnt <= '0;
                phase     <= 1'b1;
              end
            end
          end

          S_HOLD: begin
            // The blink counter free-runs; blink_en only gates visibility.
            en       <= blink_en ? phase : 1'b1;
            hold_cnt <= hold_cnt + 1'b1;
            if (blink_wrap) begin
              blink_cnt <= '0;
              phase     <= ~phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            // Always slide out visibly, even from a blinked-off frame.
            if (dismiss_pend || timeout_hit) begin
              state <= S_SLIDE_OUT;
              en    <= 1'b1;
            end
          end

          S_SLIDE_OUT: begin
            y_pos <= y_out_next;
            if (y_out_next == Y_START_V) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              en    <= 1'b0;
              done  <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            en    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prompt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prompt_sequencer
// Two sequencers share every input: one without timeout, one with a 5-frame
// timeout. A small synthetic raster (10 x 6, frame line 4) keeps frames
// short. Each frame tick the reference model predicts en/y_pos/busy for both
// and queues the prediction; a separate monitor pops and compares, and also
// checks done on every cycle.
// ---------------------------------------------------------------------------
module tb_prompt_sequencer;

  localparam int H_TOTAL = 10;
  localparam int V_TOTAL = 6;
  localparam int FL      = 4;
  localparam int YS      = 260;
  localparam int YT      = 250;
  localparam int STEP    = 4;
  localparam int BF      = 2;

  localparam int M_IDLE = 0;
  localparam int M_IN   = 1;
  localparam int M_HOLD = 2;
  localparam int M_OUT  = 3;

  typedef struct {
    int         dut;
    int         cycle;
    logic       en;
    logic [9:0] y;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hCount = '0;
  logic [9:0] vCount = '0;
  logic       start = 1'b0;
  logic       dismiss = 1'b0;
  logic       blink_en = 1'b0;
  logic       dut_en [2];
  logic [9:0] dut_y [2];
  logic       dut_busy [2];
  logic       dut_done [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_count = 0;
  int hc = 0;
  int vc = 0;
  exp_t exp_q[$];

  int m_mode [2];
  int m_y [2];
  int m_hold [2];
  bit m_en [2];
  bit m_start_req [2];
  bit m_dismiss_req [2];
  int m_timeout [2] = '{0, 5};
  int done_cycle [2] = '{-1, -1};

  prompt_sequencer #(
    .FRAME_LINE(FL), .Y_START(YS), .Y_TARGET(YT), .SLIDE_STEP(STEP),
    .BLINK_FRAMES(BF), .TIMEOUT_FRAMES(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .start(start), .dismiss(dismiss), .blink_en(blink_en),
    .en(dut_en[0]), .y_pos(dut_y[0]), .busy(dut_busy[0]), .done(dut_done[0])
  );

  prompt_sequencer #(
    .FRAME_LINE(FL), .Y_START(YS), .Y_TARGET(YT), .SLIDE_STEP(STEP),
    .BLINK_FRAMES(BF), .TIMEOUT_FRAMES(5)
  ) u_dut1 (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
    .start(start), .dismiss(dismiss), .blink_en(blink_en),
    .en(dut_en[1]), .y_pos(dut_y[1]), .busy(dut_busy[1]), .done(dut_done[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d]        = M_IDLE;
      m_y[d]           = YS;
      m_hold[d]        = 0;
      m_en[d]          = 1'b0;
      m_start_req[d]   = 1'b0;
      m_dismiss_req[d] = 1'b0;
      done_cycle[d]    = -1;
    end
  endtask

  // One frame of behaviour, straight from the prompt's life cycle:
  // positions move by STEP clamped to the endpoints, visibility in HOLD
  // follows the hold-frame index divided into BF-long halves.
  task automatic modelStep(input int d);
    bit leave;
    case (m_mode[d])
      M_IDLE: begin
        m_en[d] = 1'b0;
        m_y[d]  = YS;
        if (m_start_req[d]) begin
          m_mode[d]      = M_IN;
          m_en[d]        = 1'b1;
          m_start_req[d] = 1'b0;
        end
      end
      M_IN: begin
        if (m_dismiss_req[d]) begin
          m_mode[d]        = M_OUT;
          m_dismiss_req[d] = 1'b0;
        end else begin
          m_y[d] = (m_y[d] - STEP < YT) ? YT : m_y[d] - STEP;
          if (m_y[d] == YT) begin
            m_mode[d] = M_HOLD;
            m_hold[d] = 0;
          end
        end
      end
      M_HOLD: begin
        m_en[d] = !blink_en || (((m_hold[d] / BF) % 2) == 0);
        leave = m_dismiss_req[d] || (m_timeout[d] != 0 && m_hold[d] == m_timeout[d] - 1);
        m_hold[d]++;
        if (leave) begin
          m_mode[d]        = M_OUT;
          m_en[d]          = 1'b1;
          m_dismiss_req[d] = 1'b0;
        end
      end
      default: begin
        m_y[d] = (m_y[d] + STEP > YS) ? YS : m_y[d] + STEP;
        if (m_y[d] == YS) begin
          m_mode[d]     = M_IDLE;
          m_en[d]       = 1'b0;
          done_cycle[d] = cyc + 2;
        end
      end
    endcase
  endtask

  // Advance the raster by one pixel clock. When the frame-tick position is
  // presented, the DUT reacts two edges later; predict and queue that now.
  task automatic nextCycle();
    exp_t e;
    @(posedge clk);
    #1;
    start   = 1'b0;
    dismiss = 1'b0;
    hc = (hc + 1) % H_TOTAL;
    if (hc == 0) vc = (vc + 1) % V_TOTAL;
    hCount = 10'(hc);
    vCount = 10'(vc);
    if (rst && hc == 0 && vc == FL) begin
      for (int d = 0; d < 2; d++) begin
        modelStep(d);
        e.dut   = d;
        e.cycle = cyc + 2;
        e.en    = m_en[d];
        e.y     = 10'(m_y[d]);
        e.busy  = (m_mode[d] != M_IDLE);
        exp_q.push_back(e);
      end
      tick_count++;
    end
  endtask

  task automatic waitLine1();
    for (int i = 0; i < H_TOTAL * V_TOTAL + 2 && vc != 1; i++) nextCycle();
  endtask

  task automatic runFrames(input int n);
    int target;
    target = tick_count + n;
    for (int i = 0; i < n * H_TOTAL * V_TOTAL + 4 && tick_count < target; i++) nextCycle();
  endtask

  // Issue a one-cycle start/dismiss pulse mid-frame and set blink_en.
  task automatic applyStimulus(input bit s, input bit dm, input bit b);
    waitLine1();
    blink_en = b;
    start    = s;
    dismiss  = dm;
    for (int d = 0; d < 2; d++) begin
      if (s && m_mode[d] == M_IDLE) m_start_req[d] = 1'b1;
      if (dm && (m_mode[d] == M_IN || m_mode[d] == M_HOLD)) m_dismiss_req[d] = 1'b1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_en%0d", tag, d), {9'd0, dut_en[d]}, 10'd0);
      checkOutput($sformatf("%s_y%0d", tag, d), dut_y[d], 10'(YS));
      checkOutput($sformatf("%s_busy%0d", tag, d), {9'd0, dut_busy[d]}, 10'd0);
      checkOutput($sformatf("%s_done%0d", tag, d), {9'd0, dut_done[d]}, 10'd0);
    end
  endtask

  // Monitor: done every cycle, queued frame predictions when they fall due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++)
        checkOutput($sformatf("done%0d", d), {9'd0, dut_done[d]}, {9'd0, cyc == done_cycle[d]});
      while (exp_q.size() > 0 && exp_q[0].cycle <= cyc) begin
        e = exp_q.pop_front();
        if (e.cycle < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL late_frame dut%0d due=%0d now=%0d", e.dut, e.cycle, cyc);
        end else begin
          checkOutput($sformatf("en%0d", e.dut), {9'd0, dut_en[e.dut]}, {9'd0, e.en});
          checkOutput($sformatf("y%0d", e.dut), dut_y[e.dut], e.y);
          checkOutput($sformatf("busy%0d", e.dut), {9'd0, dut_busy[e.dut]}, {9'd0, e.busy});
        end
      end
    end
  end

  initial begin
    int guard;
    modelReset();
    #1 rst = 1'b0;
    repeat (5) nextCycle();
    rst = 1'b1;
    #1;
    checkResetValues("reset");
    $display("[TB] idle frames");
    runFrames(3);

    $display("[TB] slide in, blink, timeout on second unit");
    applyStimulus(1'b1, 1'b0, 1'b1);
    runFrames(10);

    $display("[TB] start during hold is ignored");
    applyStimulus(1'b1, 1'b0, 1'b1);
    runFrames(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runFrames(3);

    $display("[TB] dismiss in a blinked-off frame");
    applyStimulus(1'b0, 1'b0, 1'b1);
    guard = 0;
    while (guard < 12 && !(m_mode[0] == M_HOLD && !m_en[0])) begin
      runFrames(1);
      guard++;
    end
    checks++;
    if (!(m_mode[0] == M_HOLD && !m_en[0])) begin
      errors++;
      $display("[TB] FAIL blink_off_wait got=%0d expected=0", m_en[0]);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    runFrames(6);

    $display("[TB] start and dismiss together in idle");
    applyStimulus(1'b1, 1'b1, 1'b0);
    runFrames(3);
    checks++;
    if (m_y[0] != 252) begin
      errors++;
      $display("[TB] FAIL model_pos_before_reset got=%0d expected=252", m_y[0]);
    end

    $display("[TB] reset mid slide-in");
    waitLine1();
    rst = 1'b0;
    #1;
    checkResetValues("midreset");
    nextCycle();
    nextCycle();
    rst = 1'b1;
    modelReset();
    runFrames(3);

    $display("[TB] random frames");
    for (int i = 0; i < 50; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      runFrames(1);
    end
    repeat (5) nextCycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_predictions got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
